// File: rtl/simplez_ctrl_if.sv
// Control bundle between the Simplez sequencer and its datapath:
// opcode/flag inputs and all micro-order outputs.
interface simplez_ctrl_if;
  logic [2:0] co;
  logic       z;
  logic       lec;
  logic       esc;
  logic       era;
  logic       eri;
  logic       sri;
  logic       scp;
  logic       ecp;
  logic       incp;
  logic       ccp;
  logic       eac;
  logic       sac;
  logic [1:0] alu_op;
  logic       stop;
  logic [1:0] state;

  modport master (
    input  co, z,
    output lec, esc, era, eri, sri, scp, ecp, incp, ccp, eac, sac, alu_op, stop, state
  );

  modport slave (
    output co, z,
    input  lec, esc, era, eri, sri, scp, ecp, incp, ccp, eac, sac, alu_op, stop, state
  );
endinterface

// File: rtl/simplez_ctrl.sv
// Simplez control unit: four-state I0/I1/O0/O1 sequencer producing every datapath micro-order.
// Optional single-step input enabled by defining SIMPLEZ_STEP_EN.
module simplez_ctrl (
  input  logic            clk,
  input  logic            rstn,
`ifdef SIMPLEZ_STEP_EN
  input  logic            step,
`endif
  simplez_ctrl_if.master  bus
);

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_DEC  = 2'b10;
  localparam logic [1:0] ALU_CLR  = 2'b11;

  localparam logic [2:0] OP_ST   = 3'd0;
  localparam logic [2:0] OP_LD   = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;
  localparam logic [2:0] OP_BZ   = 3'd4;
  localparam logic [2:0] OP_CLR  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;

  typedef enum logic [1:0] {
    I0 = 2'd0,
    I1 = 2'd1,
    O0 = 2'd2,
    O1 = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic   run_w;

  logic       lec, esc, era, eri, sri, scp, ecp, incp, ccp, eac, sac, stop;
  logic [1:0] aluOp;

`ifdef SIMPLEZ_STEP_EN
  assign run_w = step;
`else
  assign run_w = 1'b1;
`endif

  // The datapath registers also update on the falling edge, so the sequencer does too.
  always_ff @(negedge clk) begin
    if (!rstn) state_q <= I0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = I0;
    lec     = 1'b0;
    esc     = 1'b0;
    era     = 1'b0;
    eri     = 1'b0;
    sri     = 1'b0;
    scp     = 1'b0;
    ecp     = 1'b0;
    incp    = 1'b0;
    ccp     = 1'b0;
    eac     = 1'b0;
    sac     = 1'b0;
    stop    = 1'b0;
    aluOp   = ALU_PASS;

    unique case (state_q)
      I0: begin
        if (run_w) begin
          lec     = 1'b1;
          eri     = 1'b1;
          incp    = 1'b1;
          state_d = I1;
        end else begin
          state_d = I0;
        end
      end

      I1: begin
        case (bus.co)
          OP_ST, OP_LD, OP_ADD: begin
            sri     = 1'b1;
            era     = 1'b1;
            state_d = O0;
          end
          OP_BR: begin
            sri = 1'b1;
            era = 1'b1;
            ecp = 1'b1;
          end
          OP_BZ: begin
            era = 1'b1;
            if (bus.z) begin
              sri = 1'b1;
              ecp = 1'b1;
            end else begin
              scp = 1'b1;
            end
          end
          OP_CLR: begin
            eac   = 1'b1;
            aluOp = ALU_CLR;
            scp   = 1'b1;
            era   = 1'b1;
          end
          OP_DEC: begin
            eac   = 1'b1;
            aluOp = ALU_DEC;
            scp   = 1'b1;
            era   = 1'b1;
          end
          default: begin
            // HALT parks the sequencer here until reset.
            stop    = 1'b1;
            state_d = I1;
          end
        endcase
      end

      O0: begin
        state_d = O1;
        case (bus.co)
          OP_ST: begin
            sac = 1'b1;
            esc = 1'b1;
          end
          OP_LD: begin
            lec = 1'b1;
            eac = 1'b1;
          end
          OP_ADD: begin
            lec   = 1'b1;
            eac   = 1'b1;
            aluOp = ALU_ADD;
          end
          default: ;
        endcase
      end

      O1: begin
        scp = 1'b1;
        era = 1'b1;
      end

      default: state_d = I0;
    endcase

    if (!rstn) begin
      lec   = 1'b0;
      esc   = 1'b0;
      era   = 1'b0;
      eri   = 1'b0;
      sri   = 1'b0;
      scp   = 1'b0;
      ecp   = 1'b0;
      incp  = 1'b0;
      ccp   = 1'b1;
      eac   = 1'b0;
      sac   = 1'b0;
      stop  = 1'b0;
      aluOp = ALU_PASS;
    end
  end

  assign bus.lec    = lec;
  assign bus.esc    = esc;
  assign bus.era    = era;
  assign bus.eri    = eri;
  assign bus.sri    = sri;
  assign bus.scp    = scp;
  assign bus.ecp    = ecp;
  assign bus.incp   = incp;
  assign bus.ccp    = ccp;
  assign bus.eac    = eac;
  assign bus.sac    = sac;
  assign bus.alu_op = aluOp;
  assign bus.stop   = stop;
  assign bus.state  = state_q;

endmodule
